// File: rtl/exec_pkg.sv
// exec_pkg: opcodes, FSM state type and opcode classification helpers for exec_unit.
package exec_pkg;
    localparam logic [3:0] OP_LOD  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LODI = 4'h5;
    localparam logic [3:0] OP_NAND = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_SHL  = 4'hB;
    localparam logic [3:0] OP_SHR  = 4'hC;

    typedef enum logic {IDLE, MEM} state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return op == OP_LOD || op == OP_STR;
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return op >= OP_ADD && op <= OP_SHR;
    endfunction
endpackage

// File: rtl/exec_if.sv
// exec_if: memory request/ready bus between exec_unit (master) and memory (slave).
interface exec_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data_out;
    logic [WIDTH-1:0] mem_data_in;
    logic             mem_req;
    logic             we;
    logic             mem_ready;

    modport master(output mem_addr, mem_data_out, mem_req, we, input mem_data_in, mem_ready);
    modport slave(input mem_addr, mem_data_out, mem_req, we, output mem_data_in, mem_ready);
endinterface

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU for exec_unit; carry output exists only with EXEC_FLAGS_EN.
module exec_alu
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef EXEC_FLAGS_EN
    output logic             carry,
`endif
    output logic [WIDTH-1:0] res
);
    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] amt;

    assign amt = b[SW-1:0];

    always_comb begin
        res = '0;
        case (op)
            OP_ADD, OP_ADDI: res = a + b;
            OP_SUB:          res = a - b;
            OP_LODI:         res = a;
            OP_NAND:         res = ~(a & b);
            OP_AND:          res = a & b;
            OP_OR:           res = a | b;
            OP_XOR:          res = a ^ b;
            OP_SHL:          res = a << amt;
            OP_SHR:          res = a >> amt;
            default:         res = '0;
        endcase
    end

`ifdef EXEC_FLAGS_EN
    logic [WIDTH:0] sum, dif, shl, shr;

    // One spare bit on each side captures carry/borrow and the last bit shifted out
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        dif   = {1'b0, a} - {1'b0, b};
        shl   = {1'b0, a} << amt;
        shr   = {a, 1'b0} >> amt;
        carry = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: carry = sum[WIDTH];
            OP_SUB:          carry = dif[WIDTH];
            OP_SHL:          carry = shl[WIDTH];
            OP_SHR:          carry = shr[0];
            default:         carry = 1'b0;
        endcase
    end
`endif
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage with one-cycle ALU ops and request/ready load/store with timeout.
// Optional zero/carry flag outputs are enabled by defining EXEC_FLAGS_EN.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic [WIDTH-1:0] addr_in,
    output logic [WIDTH-1:0] val_out,
    output logic             busy,
    output logic             done,
    output logic             err,
`ifdef EXEC_FLAGS_EN
    output logic             zero,
    output logic             carry,
`endif
    exec_if.master           mem
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] alu_res;
    logic             hit, tmo;
`ifdef EXEC_FLAGS_EN
    logic             alu_c;
`endif

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .op(op),
        .a(val1),
        .b(val2),
`ifdef EXEC_FLAGS_EN
        .carry(alu_c),
`endif
        .res(alu_res)
    );

    assign busy = state != IDLE;

    // A ready in the final timeout cycle counts as a normal completion
    always_comb begin
        hit     = state == MEM && mem.mem_ready;
        tmo     = state == MEM && !mem.mem_ready && MEM_TIMEOUT > 0 && cnt == CW'(MEM_TIMEOUT - 1);
        state_n = state == IDLE ? (start && is_mem_op(op) ? MEM : IDLE) : (hit || tmo ? IDLE : MEM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_out          <= '0;
            done             <= 1'b0;
            err              <= 1'b0;
            cnt              <= '0;
            op_q             <= '0;
            mem.mem_addr     <= '0;
            mem.mem_data_out <= '0;
            mem.mem_req      <= 1'b0;
            mem.we           <= 1'b0;
`ifdef EXEC_FLAGS_EN
            zero             <= 1'b0;
            carry            <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (state == IDLE && start) begin
                if (is_mem_op(op)) begin
                    op_q             <= op;
                    cnt              <= '0;
                    mem.mem_addr     <= addr_in;
                    mem.mem_req      <= 1'b1;
                    mem.we           <= op == OP_STR;
                    mem.mem_data_out <= op == OP_STR ? val1 : '0;
                end else if (is_alu_op(op)) begin
                    val_out <= alu_res;
                    done    <= 1'b1;
`ifdef EXEC_FLAGS_EN
                    zero    <= alu_res == '0;
                    carry   <= alu_c;
`endif
                end else begin
                    done <= 1'b1;
                    err  <= 1'b1;
                end
            end else if (hit) begin
                mem.mem_req <= 1'b0;
                mem.we      <= 1'b0;
                done        <= 1'b1;
                if (op_q == OP_LOD) begin
                    val_out <= mem.mem_data_in;
`ifdef EXEC_FLAGS_EN
                    zero    <= mem.mem_data_in == '0;
                    carry   <= 1'b0;
`endif
                end
            end else if (tmo) begin
                mem.mem_req <= 1'b0;
                mem.we      <= 1'b0;
                done        <= 1'b1;
                err         <= 1'b1;
            end else if (state == MEM) begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed literal checks plus randomized traffic against a behavioural model.
module tb_exec_unit;
    localparam int W  = 8;
    localparam int TO = 4;
    localparam int M  = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] val1 = '0, val2 = '0, addr_in = '0;
    logic [W-1:0] val_out;
    logic         busy, done, err;
`ifdef EXEC_FLAGS_EN
    logic         zero, carry;
`endif
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    exec_if #(.WIDTH(W)) mem_if();

    exec_unit #(.WIDTH(W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .val1(val1),
        .val2(val2),
        .addr_in(addr_in),
        .val_out(val_out),
        .busy(busy),
        .done(done),
        .err(err),
`ifdef EXEC_FLAGS_EN
        .zero(zero),
        .carry(carry),
`endif
        .mem(mem_if.master)
    );

    function automatic int ref_res(int o, int a, int b);
        int s = b % W;
        case (o)
            3, 4:    return (a + b) % M;
            5:       return a;
            6:       return (M - 1) - (a & b);
            7:       return (a - b + M) % M;
            8:       return a & b;
            9:       return a | b;
            10:      return a ^ b;
            11:      return (a << s) % M;
            12:      return a >> s;
            default: return 0;
        endcase
    endfunction

    function automatic int ref_carry(int o, int a, int b);
        int s = b % W;
        case (o)
            3, 4:    return (a + b) >= M ? 1 : 0;
            7:       return a < b ? 1 : 0;
            11:      return s == 0 ? 0 : (a >> (W - s)) & 1;
            12:      return s == 0 ? 0 : (a >> (s - 1)) & 1;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
        end
    endtask

    int m_val, m_addr, m_dout, m_wait;
    bit m_busy, m_req, m_we, m_done, m_err, m_ld, m_zero, m_carry;

    // Reference: a transaction either finishes at once (ALU/illegal) or waits for ready or TO idle cycles
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_busy, m_req, m_we, m_done, m_err, m_ld, m_zero, m_carry} <= '0;
            m_val <= 0; m_addr <= 0; m_dout <= 0; m_wait <= 0;
        end else begin
            m_done <= 0;
            m_err  <= 0;
            if (!m_busy && start) begin
                if (op == 1 || op == 2) begin
                    m_busy <= 1; m_req <= 1; m_we <= op == 2; m_ld <= op == 1; m_wait <= 0;
                    m_addr <= addr_in;
                    m_dout <= op == 2 ? int'(val1) : 0;
                end else if (op >= 3 && op <= 12) begin
                    m_val   <= ref_res(op, val1, val2);
                    m_zero  <= ref_res(op, val1, val2) == 0;
                    m_carry <= ref_carry(op, val1, val2) == 1;
                    m_done  <= 1;
                end else begin
                    m_done <= 1; m_err <= 1;
                end
            end else if (m_busy && mem_if.mem_ready) begin
                m_busy <= 0; m_req <= 0; m_we <= 0; m_done <= 1;
                if (m_ld) begin
                    m_val <= mem_if.mem_data_in; m_zero <= mem_if.mem_data_in == 0; m_carry <= 0;
                end
            end else if (m_busy) begin
                m_wait <= m_wait + 1;
                if (m_wait + 1 == TO) begin
                    m_busy <= 0; m_req <= 0; m_we <= 0; m_done <= 1; m_err <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("val_out", val_out, m_val);
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("err", err, m_err);
            check("mem_req", mem_if.mem_req, m_req);
            check("we", mem_if.we, m_we);
            check("mem_addr", mem_if.mem_addr, m_addr);
            check("mem_data_out", mem_if.mem_data_out, m_dout);
`ifdef EXEC_FLAGS_EN
            check("zero", zero, m_zero);
            check("carry", carry, m_carry);
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] ad);
        start = 1; op = o; val1 = a; val2 = b; addr_in = ad;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        mem_if.mem_ready = 0;
        mem_if.mem_data_in = '0;
        cyc(2);
        check("rst_val_out", val_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mem_req", mem_if.mem_req, 0);
        rst = 0;
        cyc(1);
        issue(4'h3, 8'hF0, 8'h20, 8'h00);
        check("add_val", val_out, 8'h10);
        check("add_done", done, 1);
        check("add_err", err, 0);
`ifdef EXEC_FLAGS_EN
        check("add_carry", carry, 1);
        check("add_zero", zero, 0);
`endif
        cyc(1);
        check("add_done_pulse", done, 0);
        issue(4'h1, 8'h00, 8'h00, 8'h3C);
        check("lod_req", mem_if.mem_req, 1);
        check("lod_we", mem_if.we, 0);
        check("lod_addr", mem_if.mem_addr, 8'h3C);
        check("lod_busy", busy, 1);
        cyc(1);
        start = 1; op = 4'h7; val1 = 8'h09; val2 = 8'h03;
        cyc(1);
        start = 0; mem_if.mem_ready = 1; mem_if.mem_data_in = 8'hA5;
        cyc(1);
        mem_if.mem_ready = 0;
        check("lod_done", done, 1);
        check("lod_val", val_out, 8'hA5);
        check("lod_req_low", mem_if.mem_req, 0);
        cyc(1);
        check("lod_single_done", done, 0);
        check("sub_ignored", val_out, 8'hA5);
        issue(4'h2, 8'h5A, 8'h00, 8'h11);
        for (int i = 0; i < TO; i++) begin
            check("str_req", mem_if.mem_req, 1);
            check("str_we", mem_if.we, 1);
            check("str_data", mem_if.mem_data_out, 8'h5A);
            cyc(1);
        end
        check("tmo_done", done, 1);
        check("tmo_err", err, 1);
        check("tmo_req", mem_if.mem_req, 0);
        check("tmo_val", val_out, 8'hA5);
        cyc(1);
        issue(4'hF, 8'h12, 8'h34, 8'h56);
        check("ill_done", done, 1);
        check("ill_err", err, 1);
        check("ill_req", mem_if.mem_req, 0);
        check("ill_val", val_out, 8'hA5);
        cyc(1);
        issue(4'h1, 8'h00, 8'h00, 8'h77);
        cyc(1);
        rst = 1;
        #1;
        check("arst_req", mem_if.mem_req, 0);
        check("arst_busy", busy, 0);
        check("arst_val", val_out, 0);
        check("arst_addr", mem_if.mem_addr, 0);
        cyc(1);
        rst = 0;
        cyc(1);
        check("arst_no_done", done, 0);
        for (int i = 0; i < 3000; i++) begin
            start = $urandom_range(0, 2) == 0;
            op = 4'($urandom_range(0, 15));
            val1 = W'($urandom);
            val2 = W'($urandom);
            addr_in = W'($urandom);
            mem_if.mem_ready = $urandom_range(0, 2) == 0;
            mem_if.mem_data_in = W'($urandom);
            rst = $urandom_range(0, 299) == 0;
            cyc(1);
        end
        rst = 0;
        start = 0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
# exec_unit

Parametrised execute stage for the bf8b core, successor to the fixed 8-bit executor. It accepts one decoded instruction per `start` pulse and performs ALU ops in one cycle or load/store ops through a request/ready memory handshake with an optional timeout. It sits between decode and register writeback and reports completion with a single-cycle `done` pulse, plus `err` for illegal opcodes and memory timeouts.

## Interface
- `WIDTH`, 8: data and address width in bits (≥4).
- `MEM_TIMEOUT`, 16: max cycles waiting for `mem_ready`; 0 waits forever.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: sampled only in IDLE; latches `op`, `val1`, `val2`, `addr_in`.
- `op` in 4: opcode.
- `val1`, `val2` in WIDTH: operands; `val1` is store data for STR and the immediate for LODI.
- `addr_in` in WIDTH: memory address for LOD/STR.
- `mem_data_in` in WIDTH: load data, valid when `mem_ready`=1.
- `mem_ready` in 1: memory completion strobe.
- `val_out` out WIDTH: result register.
- `mem_addr`, `mem_data_out` out WIDTH: memory request address/data.
- `mem_req` out 1: request held high until completion or timeout.
- `we` out 1: write enable, high with `mem_req` for STR only.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `done` on failure.

## Operation
- Opcodes: LOD=1, STR=2, ADD=3, ADDI=4, LODI=5, NAND=6, SUB=7, AND=8, OR=9, XOR=A, SHL=B, SHR=C. 0, D–F illegal.
- Arithmetic modulo 2^WIDTH; ADD/ADDI = val1+val2; SUB = val1−val2; SHL/SHR logical, amount = `val2[$clog2(WIDTH)-1:0]`; LODI: `val_out`=val1.
- States: IDLE, MEM.
- IDLE + `start`, ALU/LODI op: `val_out` updated, `done`=1 on same edge; stay IDLE.
- IDLE + `start`, illegal op: `done`=1, `err`=1, `val_out` unchanged.
- IDLE + `start`, LOD/STR: `mem_addr`←`addr_in`, `mem_req`←1, `we`←(STR), `mem_data_out`←val1 (STR) else 0, timeout counter cleared; → MEM.
- MEM + `mem_ready`: `mem_req`,`we`←0; LOD writes `val_out`←`mem_data_in`; `done`=1; → IDLE.
- MEM, no `mem_ready`, counter reaches MEM_TIMEOUT−1 (MEM_TIMEOUT>0): `mem_req`,`we`←0, `done`=`err`=1, `val_out` unchanged; → IDLE. `mem_ready` in that same cycle wins (normal completion).
- `start` while in MEM ignored; inputs not relatched.
- `mem_ready` in IDLE ignored.

## Timing
- Reset values: `val_out`, `mem_addr`, `mem_data_out` = 0; `mem_req`, `we`, `busy`, `done`, `err`, flags = 0; state IDLE; counter 0.
- Reset mid-MEM drops `mem_req`/`we` immediately (asynchronous); no `done` generated.
- ALU latency: `done` high in the cycle after the `start` edge.
- Memory latency: `mem_req` rises cycle after `start`; `done` rises cycle after `mem_ready` sampled; minimum 2 cycles.
- Back-to-back: `start` may be high in the same cycle `done` is high.
- Timeout: `err` in cycle MEM_TIMEOUT+1 after `start` edge.

## Configuration
- `EXEC_FLAGS_EN` defined: adds outputs `zero` and `carry` (1 bit each), registered with `done`. `zero` = (result==0) for ALU, LODI, LOD; `carry` = carry-out for ADD/ADDI, borrow for SUB, last bit shifted out for SHL/SHR (0 if amount 0), 0 otherwise. STR, illegal and timeout leave flags unchanged.
- Undefined: ports absent, no flag logic.

## Structure
- Package `exec_pkg`: opcode localparams, state enum, `is_mem_op()` helper.
- Sub-module `exec_alu`: combinational, WIDTH-parametrised, computes result and carry from op/val1/val2.
- Top holds FSM, operand latch, timeout counter, output registers.

## Test plan
- WIDTH=8, ADD 0xF0+0x20 -> `val_out`=0x10, `carry`=1, `zero`=0, `done` one cycle after `start`.
- LOD addr 0x3C, `mem_ready` 3 cycles after `mem_req`, `mem_data_in`=0xA5 -> `val_out`=0xA5, `we`=0 throughout, `mem_req` low next cycle.
- STR val1=0x5A, MEM_TIMEOUT=4, no `mem_ready` -> `we`/`mem_req` high 4 cycles, then `done`=`err`=1, `val_out` unchanged.
- op=0xF -> `done`=`err`=1 next cycle, no `mem_req`.
- `start` with SUB during MEM -> ignored; LOD completes normally, only one `done`.
- `rst` pulsed mid-MEM -> `mem_req`=0 immediately, all outputs 0, no `done`.
